// File: rtl/hc165_reader.sv
// Scan controller for a chain of parallel-in/serial-out shift registers.
// It drives the load and clock pins, samples the serial output MSB-first and offers each word on valid/ready.
module hc165_reader #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             auto,
    output logic             busy,
    output logic             sr_clk,
    output logic             sr_shld,
    output logic             sr_clk_inh,
    input  logic             sr_q,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LO,
        LOAD_HI,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [PW-1:0]    phase;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] acc;
    logic             phase_end;
    logic             sample;
    logic             clk_nx;
    logic             shld_nx;
    logic             inh_nx;
    logic             busy_nx;

    assign phase_end = (phase == PH_LAST);
    assign sample    = (state == SHIFT_LO) && phase_end;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start || auto) state_nx = LOAD_LO;
            LOAD_LO:  if (phase_end) state_nx = LOAD_HI;
            LOAD_HI:  if (phase_end) state_nx = SHIFT_LO;
            SHIFT_LO: if (phase_end) state_nx = (bit_cnt == BIT_LAST) ? DONE : SHIFT_HI;
            SHIFT_HI: if (phase_end) state_nx = SHIFT_LO;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Pin levels are decoded from the next state so the registered pins line up with the state register.
    always_comb begin
        clk_nx  = 1'b0;
        shld_nx = 1'b1;
        inh_nx  = 1'b0;
        busy_nx = 1'b1;
        case (state_nx)
            IDLE: begin
                inh_nx  = 1'b1;
                busy_nx = 1'b0;
            end
            LOAD_LO:  shld_nx = 1'b0;
            LOAD_HI: begin
                clk_nx  = 1'b1;
                shld_nx = 1'b0;
            end
            SHIFT_LO: clk_nx = 1'b0;
            SHIFT_HI: clk_nx = 1'b1;
            DONE:     inh_nx = 1'b1;
            default: begin
                inh_nx  = 1'b1;
                busy_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= '0;
            sr_clk     <= 1'b0;
            sr_shld    <= 1'b1;
            sr_clk_inh <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            phase      <= (state_nx != state) ? '0 : phase + 1'b1;
            sr_clk     <= clk_nx;
            sr_shld    <= shld_nx;
            sr_clk_inh <= inh_nx;
            busy       <= busy_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            acc     <= '0;
        end else begin
            if (state == LOAD_HI)
                bit_cnt <= '0;
            else if (sample)
                bit_cnt <= bit_cnt + 1'b1;
            if (sample)
                acc <= {acc[WIDTH-2:0], sr_q};
        end
    end

    // A word landing in DONE always wins over a same-cycle accept; it only overruns if nobody took the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (state == DONE) begin
            data_out   <= acc;
            data_valid <= 1'b1;
            overrun    <= data_valid && !data_ready;
        end else begin
            overrun <= 1'b0;
            if (data_valid && data_ready)
                data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hc165_reader.sv
// Directed bench for hc165_reader: one 8-bit device at CLK_DIV=4 and a two-device chain at CLK_DIV=1,
// each fed by a behavioural shift-register model.
module tb_hc165_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8, auto8, ready8, busy8, sclk8, shld8, inh8, q8, valid8, ovr8;
    logic [7:0] dout8;
    logic       start16, auto16, ready16, busy16, sclk16, shld16, inh16, q16, valid16, ovr16;
    logic [15:0] dout16;

    hc165_reader #(.WIDTH(8), .CLK_DIV(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .auto(auto8), .busy(busy8),
        .sr_clk(sclk8), .sr_shld(shld8), .sr_clk_inh(inh8), .sr_q(q8),
        .data_out(dout8), .data_valid(valid8), .data_ready(ready8), .overrun(ovr8)
    );

    hc165_reader #(.WIDTH(16), .CLK_DIV(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .auto(auto16), .busy(busy16),
        .sr_clk(sclk16), .sr_shld(shld16), .sr_clk_inh(inh16), .sr_q(q16),
        .data_out(dout16), .data_valid(valid16), .data_ready(ready16), .overrun(ovr16)
    );

    // Single device: load on a rising edge while shld is low, otherwise shift toward Q.
    logic [7:0] par8;
    logic [7:0] m8;
    int edges8 = 0;
    int low8 = 0;
    int last_low8 = -1;
    always @(posedge sclk8) begin
        if (!shld8) begin
            m8        <= par8;
            low8      <= low8 + 1;
            last_low8 <= edges8;
        end else begin
            m8 <= {m8[6:0], 1'b0};
        end
        edges8 <= edges8 + 1;
    end
    assign q8 = m8[7];

    // Two chained devices: a drives the reader, b feeds a's serial input.
    logic [7:0] a16, b16;
    int edges16 = 0;
    always @(posedge sclk16) begin
        if (!shld16) begin
            a16 <= 8'h3C;
            b16 <= 8'hC3;
        end else begin
            a16 <= {a16[6:0], b16[7]};
            b16 <= {b16[6:0], 1'b0};
        end
        edges16 <= edges16 + 1;
    end
    assign q16 = a16[7];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (valid8 !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat, n, base, lowb;

    initial begin
        start8 = 0; auto8 = 0; ready8 = 0; par8 = 8'hA5;
        start16 = 0; auto16 = 0; ready16 = 0;
        repeat (3) @(negedge clk);

        check("rst_busy",  busy8,  1'b0);
        check("rst_sclk",  sclk8,  1'b0);
        check("rst_shld",  shld8,  1'b1);
        check("rst_inh",   inh8,   1'b1);
        check("rst_valid", valid8, 1'b0);
        check("rst_dout",  dout8,  8'h00);
        check("rst_ovr",   ovr8,   1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single scan of 8'hA5
        base = edges8; lowb = low8;
        start8 = 1; @(negedge clk); start8 = 0;
        check("load_busy", busy8, 1'b1);
        check("load_shld", shld8, 1'b0);
        check("load_inh",  inh8,  1'b0);
        check("load_sclk", sclk8, 1'b0);
        wait8(lat);
        check("scan1_lat",    lat, 69);
        check("scan1_dout",   dout8, 8'hA5);
        check("scan1_edges",  edges8 - base, 8);
        check("scan1_lowcnt", low8 - lowb, 1);
        check("scan1_lowidx", last_low8, base);
        check("scan1_idle",   busy8, 1'b0);
        check("scan1_ovr",    ovr8, 1'b0);
        ready8 = 1; @(negedge clk); ready8 = 0;
        check("accept1", valid8, 1'b0);

        // start while busy must be ignored
        par8 = 8'h5A; base = edges8;
        start8 = 1; @(negedge clk); start8 = 0;
        repeat (20) @(negedge clk);
        start8 = 1; @(negedge clk); start8 = 0;
        wait8(lat);
        check("busy_dout", dout8, 8'h5A);
        repeat (100) @(negedge clk);
        check("busy_edges", edges8 - base, 8);
        check("busy_idle",  busy8, 1'b0);
        ready8 = 1; @(negedge clk); ready8 = 0;

        // Reset in SHIFT_HI after the fifth rising edge
        par8 = 8'h99; base = edges8;
        start8 = 1; @(negedge clk); start8 = 0;
        n = 0;
        while (edges8 - base < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach", edges8 - base, 5);
        check("mid_sclk_hi", sclk8, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_sclk",  sclk8,  1'b0);
        check("mid_busy",  busy8,  1'b0);
        check("mid_shld",  shld8,  1'b1);
        check("mid_inh",   inh8,   1'b1);
        check("mid_dout",  dout8,  8'h00);
        check("mid_valid", valid8, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("post_valid", valid8, 1'b0);
        check("post_busy",  busy8,  1'b0);
        par8 = 8'hC7; base = edges8;
        start8 = 1; @(negedge clk); start8 = 0;
        wait8(lat);
        check("rescan_lat",   lat, 69);
        check("rescan_dout",  dout8, 8'hC7);
        check("rescan_edges", edges8 - base, 8);
        ready8 = 1; @(negedge clk); ready8 = 0;

        // Backpressure with auto
        par8 = 8'hA1; auto8 = 1;
        wait8(lat);
        check("bp1_dout", dout8, 8'hA1);
        check("bp1_ovr",  ovr8,  1'b0);
        par8 = 8'hB2;
        n = 0;
        while (ovr8 !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("bp2_period", n, 70);
        check("bp2_dout",   dout8, 8'hB2);
        check("bp2_valid",  valid8, 1'b1);
        par8 = 8'hC3;
        @(negedge clk);
        check("bp2_pulse", ovr8, 1'b0);
        repeat (68) @(negedge clk);
        check("bp3_busy", busy8, 1'b1);
        ready8 = 1;
        @(negedge clk);
        auto8 = 0;
        check("bp3_dout",  dout8, 8'hC3);
        check("bp3_valid", valid8, 1'b1);
        check("bp3_ovr",   ovr8, 1'b0);
        @(negedge clk);
        check("bp3_accept", valid8, 1'b0);

        // Free-running auto scans with the input changing per scan
        par8 = 8'hD4; auto8 = 1;
        wait8(lat);
        check("auto1_dout", dout8, 8'hD4);
        par8 = 8'h6E;
        n = 0;
        do begin @(negedge clk); n++; end while (valid8 !== 1'b1 && n < 300);
        check("auto2_period", n, 70);
        check("auto2_dout",   dout8, 8'h6E);
        par8 = 8'h19;
        n = 0;
        do begin @(negedge clk); n++; end while (valid8 !== 1'b1 && n < 300);
        auto8 = 0;
        check("auto3_period", n, 70);
        check("auto3_dout",   dout8, 8'h19);
        repeat (3) @(negedge clk);
        check("auto_stop", busy8, 1'b0);
        ready8 = 0;

        // Two chained devices, WIDTH=16, CLK_DIV=1
        base = edges16;
        start16 = 1; @(negedge clk); start16 = 0;
        lat = 0;
        while (valid16 !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check("chain_lat",   lat, 34);
        check("chain_dout",  dout16, 16'h3CC3);
        check("chain_edges", edges16 - base, 16);
        check("chain_idle",  busy16, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hc165_reader.md
# hc165_reader

Scan controller for the parallel-in/serial-out shift-register stage. It drives the register's serial clock, load and clock-inhibit pins, and samples its serial output MSB-first. It reassembles the stream into a WIDTH-bit parallel word and presents it on a valid/ready interface. It sits directly downstream of the shift register(s), which may be one device or several daisy-chained, and upstream of whatever logic consumes the input snapshot.

## Interface
Parameters:
- WIDTH, 8: total bits per scan (8 × number of chained devices); legal range ≥ 2.
- CLK_DIV, 4: `clk` cycles per serial-clock phase (half-period); legal range ≥ 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request one scan; sampled only in IDLE.
- auto  in  1  when high, IDLE starts a new scan without `start`.
- busy  out  1  high in every state except IDLE.
- sr_clk  out  1  serial clock to the shift register.
- sr_shld  out  1  active-low load to the shift register.
- sr_clk_inh  out  1  clock inhibit to the shift register; high when idle.
- sr_q  in  1  serial data from the shift register's true output.
- data_out  out  WIDTH  last completed scan; data_out[WIDTH-1] is the first bit received.
- data_valid  out  1  data_out holds an unconsumed word.
- data_ready  in  1  consumer accepts when `data_valid & data_ready`.
- overrun  out  1  one-cycle pulse: an unconsumed word was overwritten.

## Operation
- All outputs are registered.
- A phase counter counts CLK_DIV cycles per state; every state below except IDLE and DONE lasts exactly CLK_DIV cycles.
- A bit counter runs 0..WIDTH-1. The accumulator `acc` is WIDTH bits.

States:
- IDLE
  - Outputs: sr_clk=0, sr_shld=1, sr_clk_inh=1, busy=0.
  - Leaves to LOAD_LO when `start | auto`.
- LOAD_LO
  - Outputs: sr_clk=0, sr_shld=0, sr_clk_inh=0.
  - Always leaves to LOAD_HI.
- LOAD_HI
  - Outputs: sr_clk=1, sr_shld=0.
  - The rising edge of sr_clk loads the parallel inputs.
  - Leaves to SHIFT_LO with bit counter = 0.
- SHIFT_LO
  - Outputs: sr_clk=0, sr_shld=1.
  - On its final cycle: `acc <= {acc[WIDTH-2:0], sr_q}` and the bit counter increments.
  - Leaves to DONE if the bit just sampled was bit WIDTH-1; otherwise to SHIFT_HI.
- SHIFT_HI
  - Outputs: sr_clk=1, sr_shld=1.
  - Always leaves to SHIFT_LO.
- DONE
  - Lasts 1 cycle; sr_clk=0, sr_clk_inh=1.
  - Actions: `data_out <= acc`, `data_valid <= 1`.
  - Leaves to IDLE.

Bit-count rules:
- One scan is WIDTH samples and WIDTH sr_clk rising edges: 1 load edge plus WIDTH-1 shift edges.
- No extra shift edge follows the last sample.
- sr_q is always sampled in a low phase, CLK_DIV cycles after the preceding rising edge.

Handshake and boundary rules:
- data_valid clears on `data_valid & data_ready` unless DONE occurs in the same cycle.
- DONE together with an accept in the same cycle: the new word is latched, data_valid stays 1, and overrun stays 0.
- DONE while data_valid=1 and data_ready=0: data_out is overwritten, data_valid stays 1, and overrun=1 for that cycle.
- `start` in any non-IDLE state is ignored; it is not queued.
- Changes on `auto` take effect only in IDLE.
- With `auto` held high, DONE→IDLE→LOAD_LO gives back-to-back scans with 1 IDLE cycle between them.

Reset:
- rst_n low forces IDLE immediately, mid-scan included.
- Reset values: acc=0, data_out=0, data_valid=0, overrun=0, busy=0, sr_clk=0, sr_shld=1, sr_clk_inh=1.
- A partial scan is discarded and leaves no data_valid.

## Timing
- `start` is sampled high at IDLE edge k. LOAD_LO is active after edge k, and data_valid is first high after edge k + (2·WIDTH+1)·CLK_DIV + 1.
  - WIDTH=8, CLK_DIV=4: 69 cycles.
  - WIDTH=8, CLK_DIV=1: 18 cycles.
- sr_clk period is 2·CLK_DIV clk cycles with 50% duty.
- sr_shld is low across both load phases, so it is stable before and after the load edge.
- sr_shld returns high CLK_DIV cycles before the first shift edge.
- Scan period with `auto` high: (2·WIDTH+1)·CLK_DIV + 2 cycles.
- busy rises the cycle after start is accepted and falls on IDLE entry.

## Test plan
- Single scan, using a behavioural shift-register model with parallel input 8'hA5 and WIDTH=8, CLK_DIV=4.
  - data_out=8'hA5 and data_valid high 69 cycles after start.
  - Exactly 8 sr_clk rising edges; sr_shld low at edge 1 only.
- Two chained models (8'h3C, 8'hC3) with WIDTH=16 and CLK_DIV=1.
  - data_out=16'h3CC3 after 34 cycles, first device in the MSBs.
- Backpressure: data_ready=0 with auto=1 across two scans.
  - Second DONE gives an overrun pulse of exactly 1 cycle and data_out = second word.
  - Set data_ready=1 on the DONE cycle of a third scan: no overrun, data_valid stays 1.
- rst_n low for 1 cycle in the middle of SHIFT_HI at bit 4.
  - All outputs go to reset values asynchronously, with no data_valid afterwards.
  - The next start produces a correct full word.
- Pulse start while busy: no second scan and no change in sr_clk edge count.
- auto=1 with the model input changing after each scan: consecutive words match, with a period of 70 cycles for WIDTH=8, CLK_DIV=4.
